// File: rtl/req_cond_pkg.sv
// Shared definitions for the request conditioner: requester count, parameter
// defaults and the per-channel state encoding.
package req_cond_pkg;

    localparam int unsigned NumReq         = 3;
    localparam int unsigned MaxHoldDefault = 8;
    localparam int unsigned CoolDefault    = 4;
    localparam int unsigned CntW           = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StHeld = 2'd2,
        StCool = 2'd3
    } chan_state_e;

    // A channel presents a request to the arbiter only while waiting or holding.
    function automatic logic chan_requesting(input chan_state_e st);
        return (st == StWait) || (st == StHeld);
    endfunction

endpackage

// File: rtl/req_chan.sv
// One requester channel: 2-flop synchronizer on the raw request, a
// tenure-limiting FSM with an 8-bit counter, and registered outputs.
module req_chan
    import req_cond_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MaxHoldDefault,
    parameter int unsigned COOL     = CoolDefault
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic gnt_i,
    output logic req_o,
    output logic expired_o
);

    localparam logic [CntW-1:0] MaxHoldCnt = CntW'(MAX_HOLD);
    localparam logic [CntW-1:0] CoolLast   = CntW'(COOL - 1);

    logic [1:0]      sync_q;
    logic            req_s;
    chan_state_e     st_q;
    logic [CntW-1:0] cnt_q;
    logic            req_q;
    logic            expired_q;

    assign req_s     = sync_q[1];
    assign req_o     = req_q;
    assign expired_o = expired_q;

    // Two-stage synchronizer for the asynchronous raw request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], req_i};
        end
    end

    // Channel FSM; req_q always equals the request decode of the state it moves to,
    // so the arbiter request output has no combinational path from any input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q      <= StIdle;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            case (st_q)
                StIdle: begin
                    if (req_s) begin
                        st_q  <= StWait;
                        req_q <= 1'b1;
                    end
                end
                StWait: begin
                    if (!req_s) begin
                        st_q  <= StIdle;
                        cnt_q <= '0;
                        req_q <= 1'b0;
                    end else if (gnt_i) begin
                        // The grant seen while waiting starts the tenure but is not counted.
                        st_q  <= StHeld;
                        cnt_q <= CntW'(1);
                    end
                end
                StHeld: begin
                    if (!req_s) begin
                        // Release wins over a coincident expiry: no pulse.
                        st_q  <= StIdle;
                        cnt_q <= '0;
                        req_q <= 1'b0;
                    end else if (!gnt_i) begin
                        st_q <= StWait;
                    end else if (cnt_q == MaxHoldCnt) begin
                        st_q      <= StCool;
                        cnt_q     <= '0;
                        req_q     <= 1'b0;
                        expired_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StCool: begin
                    // Grant and request are ignored until the mask has run out.
                    if (cnt_q == CoolLast) begin
                        st_q  <= StIdle;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    st_q  <= StIdle;
                    cnt_q <= '0;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // Consistency properties of the channel state.
    a_req_decode: assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_q == chan_requesting(st_q));

    a_expired_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
        expired_q |=> !expired_q);

    a_held_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (st_q == StHeld) |-> (cnt_q >= CntW'(1) && cnt_q <= MaxHoldCnt));

    a_cool_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (st_q == StCool) |-> (cnt_q <= CoolLast));

endmodule

// File: rtl/req_conditioner.sv
// Request conditioner top: one req_chan per requester, wiring only.
module req_conditioner
    import req_cond_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MaxHoldDefault,
    parameter int unsigned COOL     = CoolDefault
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NumReq-1:0] req_in,
    input  logic [NumReq-1:0] g,
    output logic [NumReq-1:0] r,
    output logic [NumReq-1:0] expired
);

    for (genvar i = 0; i < NumReq; i++) begin : g_chan
        req_chan #(
            .MAX_HOLD (MAX_HOLD),
            .COOL     (COOL)
        ) u_chan (
            .clk_i     (clk),
            .rst_ni    (resetn),
            .req_i     (req_in[i]),
            .gnt_i     (g[i]),
            .req_o     (r[i]),
            .expired_o (expired[i])
        );
    end

endmodule

// File: tb/tb_req_conditioner.sv
// Self-checking bench for req_conditioner: a behavioural reference model pushes
// expected outputs into a scoreboard queue that a separate monitor drains.
module tb_req_conditioner;

    localparam int MaxHold = 8;
    localparam int Cool    = 4;

    // Reference-model channel modes.
    localparam int MIdle = 0;
    localparam int MWait = 1;
    localparam int MHeld = 2;
    localparam int MCool = 3;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] x;
    } exp_t;

    logic       clk;
    logic       resetn;
    logic [2:0] req_in;
    logic [2:0] g;
    logic [2:0] r;
    logic [2:0] expired;

    int checks = 0;
    int errors = 0;

    exp_t sb_q[$];
    int   mode[3];
    int   tenure[3];
    int   cooled[3];
    bit   s1[3];
    bit   s2[3];

    req_conditioner #(
        .MAX_HOLD (MaxHold),
        .COOL     (Cool)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .req_in  (req_in),
        .g       (g),
        .r       (r),
        .expired (expired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] model_r();
        logic [2:0] v;
        for (int i = 0; i < 3; i++) v[i] = (mode[i] == MWait) || (mode[i] == MHeld);
        return v;
    endfunction

    function automatic logic [2:0] lowest(input logic [2:0] v);
        logic [2:0] neg;
        neg = ~v + 3'd1;
        return v & neg;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mode[i] = MIdle; tenure[i] = 0; cooled[i] = 0; s1[i] = 0; s2[i] = 0;
        end
        sb_q.delete();
    endtask

    // One clock of the behavioural model: FSM rules act on the synchronized
    // request (two samples old), then the delay line shifts.
    task automatic model_step(input logic [2:0] rin, input logic [2:0] gin);
        exp_t e;
        bit   rs;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            rs = s2[i];
            case (mode[i])
                MIdle: if (rs) mode[i] = MWait;
                MWait: begin
                    if (!rs) mode[i] = MIdle;
                    else if (gin[i]) begin mode[i] = MHeld; tenure[i] = 1; end
                end
                MHeld: begin
                    if (!rs) mode[i] = MIdle;
                    else if (!gin[i]) mode[i] = MWait;
                    else if (tenure[i] == MaxHold) begin
                        mode[i] = MCool; cooled[i] = 0; e.x[i] = 1'b1;
                    end else tenure[i]++;
                end
                default: begin
                    cooled[i]++;
                    if (cooled[i] == Cool) mode[i] = MIdle;
                end
            endcase
            s2[i] = s1[i];
            s1[i] = rin[i];
        end
        e.r = model_r();
        sb_q.push_back(e);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic tick(input logic [2:0] rin, input logic [2:0] gin);
        req_in = rin;
        g      = gin;
        @(posedge clk);
        if (resetn) model_step(rin, gin);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse starting mid-cycle; called at a negedge.
    task automatic do_reset();
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("reset_r_immediate", r, 0);
        chk("reset_x_immediate", expired, 0);
        @(posedge clk);
        #1;
        chk("reset_r_held", r, 0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Scoreboard monitor: compares every post-edge output against the queue head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (resetn && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_r", r, e.r);
            chk("sb_expired", expired, e.x);
        end
    end

    initial begin
        logic [2:0] rin;
        logic [2:0] gsel;
        logic [2:0] r_pre;
        int         run[3];
        int         max_run[3];
        int         grants[3];
        int         exp_edge;
        int         back_edge;

        resetn = 1'b0;
        req_in = 3'b111;
        g      = 3'b000;
        model_reset();
        #1;
        chk("init_r", r, 0);
        chk("init_expired", expired, 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Reset while channel 0 is mid-tenure, then re-acquire from IDLE.
        for (int k = 1; k <= 8; k++) begin
            tick(3'b111, 3'b001);
            if (k == 3) chk("rst_acquire_r", r, 3'b111);
        end
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            tick(3'b111, 3'b000);
            chk("rst_release_r", r, (k == 3) ? 3'b111 : 3'b000);
            chk("rst_release_x", expired, 0);
        end

        // Latency of rise and fall on requester 1.
        req_in = 3'b000;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            tick(3'b010, 3'b000);
            chk("lat_rise_r1", r[1], (k == 3) ? 1 : 0);
        end
        for (int k = 1; k <= 3; k++) begin
            tick(3'b000, 3'b000);
            chk("lat_fall_r1", r[1], (k == 3) ? 0 : 1);
        end

        // Forced release on channel 0 with a continuous grant.
        exp_edge  = 3 + 1 + MaxHold;
        back_edge = exp_edge + Cool + 1;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            tick(3'b001, 3'b001);
            chk("force_x0", expired[0], (k == exp_edge) ? 1 : 0);
            chk("force_r0", r[0], ((k >= 3 && k < exp_edge) || k >= back_edge) ? 1 : 0);
        end

        // Channel 2 request drops on the very cycle its count reaches MAX_HOLD.
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            tick((k <= exp_edge - 3) ? 3'b100 : 3'b000, 3'b100);
            chk("relexp_x2", expired[2], 0);
            chk("relexp_r2", r[2], (k >= 3 && k < exp_edge) ? 1 : 0);
        end

        // Channel 0 loses its grant at count 5, then tenure restarts from 1.
        do_reset();
        for (int k = 1; k <= 22; k++) begin
            tick(3'b001, (k == 9) ? 3'b000 : 3'b001);
            chk("lost_x0", expired[0], (k == 10 + MaxHold) ? 1 : 0);
            chk("lost_r0", r[0], (k >= 3 && k < 10 + MaxHold) ? 1 : 0);
        end

        // Fairness with a fixed-priority arbiter and all requests held. The grant
        // seen in WAIT precedes the tenure, so a run may be MAX_HOLD + 1 long.
        do_reset();
        for (int i = 0; i < 3; i++) begin run[i] = 0; max_run[i] = 0; grants[i] = 0; end
        for (int n = 0; n < 200; n++) begin
            gsel  = lowest(model_r());
            r_pre = r;
            tick(3'b111, gsel);
            for (int i = 0; i < 3; i++) begin
                run[i] = (gsel[i] && r_pre[i]) ? run[i] + 1 : 0;
                if (run[i] > max_run[i]) max_run[i] = run[i];
                if (gsel[i]) grants[i]++;
            end
        end
        for (int i = 0; i < 3; i++) chk("fair_max_run_ok", max_run[i] <= MaxHold + 1, 1);
        chk("fair_ch0_granted", grants[0] > 0, 1);
        chk("fair_ch1_granted", grants[1] > 0, 1);

        // Randomized traffic with a mostly well-behaved arbiter and rare resets.
        rin = 3'b000;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(99) < 8) rin[$urandom_range(2)] ^= 1'b1;
            if ($urandom_range(3) != 0) begin
                gsel = lowest(model_r());
            end else begin
                case ($urandom_range(3))
                    0: gsel = 3'b000;
                    1: gsel = 3'b001;
                    2: gsel = 3'b010;
                    default: gsel = 3'b100;
                endcase
            end
            tick(rin, gsel);
            if ($urandom_range(199) == 0) do_reset();
        end

        @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
